cpu8_ctrl_exec: RTL and testbench

Control and execute core of the 8-bit, 4-stage pipelined CPU (fetch, decode, execute, writeback). It holds three parts:
- the program counter with branch redirection;
- the combinational 13-bit instruction decoder, fed from the fetch latch;
- the combinational 8-bit ALU, fed from the decode latch.
Pipeline latches, program memory and the register file live outside this block.

---
 rtl/cpu8_pkg.sv | 39 +++
 rtl/cpu8_ctrl_exec_alu8.sv | 64 ++++++
 rtl/cpu8_ctrl_exec.sv | 83 ++++++++
 tb/tb_cpu8_ctrl_exec.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu8_pkg.sv
// Shared definitions for the cpu8 control/execute core: ALU opcodes,
// instruction field positions and basic widths.
package cpu8_pkg;

    localparam int INSTR_W    = 13;
    localparam int REG_ADDR_W = 3;
    localparam int OPCODE_W   = 3;

    // Instruction field bit positions
    localparam int BR_BIT  = 12;
    localparam int OP_MSB  = 11;
    localparam int OP_LSB  = 9;
    localparam int RA_MSB  = 8;
    localparam int RA_LSB  = 6;
    localparam int RB_MSB  = 5;
    localparam int RB_LSB  = 3;
    localparam int RD_MSB  = 2;
    localparam int RD_LSB  = 0;
    localparam int TGT_MSB = 7;
    localparam int TGT_LSB = 0;

    typedef enum logic [OPCODE_W-1:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_NOT = 3'b101,
        OP_SHL = 3'b110,
        OP_SHR = 3'b111
    } alu_op_e;

    // Branch condition select: opcode bit 0 picks "greater" over "equal".
    function automatic logic branch_cond(input logic [OPCODE_W-1:0] op,
                                         input logic gr, input logic eq);
        return op[0] ? gr : eq;
    endfunction

endpackage

// File: rtl/cpu8_ctrl_exec_alu8.sv
// Combinational 8-bit ALU: result per opcode plus unsigned compare flags
// that are always computed from the operands regardless of the opcode.
module alu8
    import cpu8_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [DATA_W-1:0]   operand_a,
    input  logic [DATA_W-1:0]   operand_b,
    output logic [DATA_W-1:0]   result,
    output logic                flg_gr,
    output logic                flg_eq
);

    logic [DATA_W-1:0] and_v;
    logic [DATA_W-1:0] or_v;
    logic [DATA_W-1:0] xor_v;
    logic [DATA_W-1:0] not_v;
    logic [DATA_W-1:0] shl_v;
    logic [DATA_W-1:0] shr_v;

    genvar gi;
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_bit
            assign and_v[gi] = operand_a[gi] & operand_b[gi];
            assign or_v[gi]  = operand_a[gi] | operand_b[gi];
            assign xor_v[gi] = operand_a[gi] ^ operand_b[gi];
            assign not_v[gi] = ~operand_a[gi];

            // Shifts zero-fill at the vacated end
            if (gi == 0) begin : g_lsb
                assign shl_v[gi] = 1'b0;
            end else begin : g_shl
                assign shl_v[gi] = operand_a[gi-1];
            end

            if (gi == DATA_W - 1) begin : g_msb
                assign shr_v[gi] = 1'b0;
            end else begin : g_shr
                assign shr_v[gi] = operand_a[gi+1];
            end
        end
    endgenerate

    always_comb begin
        result = '0;
        case (opcode)
            OP_ADD:  result = operand_a + operand_b;
            OP_SUB:  result = operand_a - operand_b;
            OP_AND:  result = and_v;
            OP_OR:   result = or_v;
            OP_XOR:  result = xor_v;
            OP_NOT:  result = not_v;
            OP_SHL:  result = shl_v;
            OP_SHR:  result = shr_v;
            default: result = '0;
        endcase
    end

    assign flg_gr = (operand_a > operand_b);
    assign flg_eq = (operand_a == operand_b);

endmodule

// File: rtl/cpu8_ctrl_exec.sv
// Control/execute core of the 4-stage cpu8: instruction decoder, branch
// condition, program counter and the execute-stage ALU.
module cpu8_ctrl_exec
    import cpu8_pkg::*;
#(
    parameter int PC_W   = 8,
    parameter int DATA_W = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [INSTR_W-1:0]    instr_i,
    output logic [PC_W-1:0]       pc_o,
    output logic [REG_ADDR_W-1:0] rd_addr_a_o,
    output logic [REG_ADDR_W-1:0] rd_addr_b_o,
    output logic [OPCODE_W-1:0]   dec_opcode_o,
    output logic                  dec_wr_en_o,
    output logic [REG_ADDR_W-1:0] dec_wr_addr_o,
    input  logic [DATA_W-1:0]     operand_a_i,
    input  logic [DATA_W-1:0]     operand_b_i,
    input  logic [OPCODE_W-1:0]   exe_opcode_i,
    output logic [DATA_W-1:0]     result_o,
    output logic                  flg_gr_o,
    output logic                  flg_eq_o,
    output logic                  branch_taken_o
);

    logic                is_branch;
    logic [OPCODE_W-1:0] instr_op;
    logic [PC_W-1:0]     pc_reg;
    logic [PC_W-1:0]     pc_next;
    logic [PC_W-1:0]     branch_target;

    assign is_branch     = instr_i[BR_BIT];
    assign instr_op      = instr_i[OP_MSB:OP_LSB];
    assign branch_target = PC_W'(instr_i[TGT_MSB:TGT_LSB]);

    // Branches carry a target in the register fields, so addresses are forced to 0
    always_comb begin
        dec_opcode_o  = instr_op;
        dec_wr_en_o   = 1'b0;
        rd_addr_a_o   = '0;
        rd_addr_b_o   = '0;
        dec_wr_addr_o = '0;
        if (!is_branch) begin
            dec_wr_en_o   = 1'b1;
            rd_addr_a_o   = instr_i[RA_MSB:RA_LSB];
            rd_addr_b_o   = instr_i[RB_MSB:RB_LSB];
            dec_wr_addr_o = instr_i[RD_MSB:RD_LSB];
        end
    end

    alu8 #(
        .DATA_W (DATA_W)
    ) u_alu (
        .opcode    (exe_opcode_i),
        .operand_a (operand_a_i),
        .operand_b (operand_b_i),
        .result    (result_o),
        .flg_gr    (flg_gr_o),
        .flg_eq    (flg_eq_o)
    );

    // Flags belong to the instruction in execute, not to the branch being decoded
    assign branch_taken_o = is_branch & branch_cond(instr_op, flg_gr_o, flg_eq_o);

    always_comb begin
        pc_next = pc_reg + PC_W'(1);
        if (branch_taken_o) begin
            pc_next = branch_target;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pc_reg <= '0;
        end else begin
            pc_reg <= pc_next;
        end
    end

    assign pc_o = pc_reg;

endmodule

// File: tb/tb_cpu8_ctrl_exec.sv
// Directed self-checking bench for cpu8_ctrl_exec: reset, decode, ALU sweep,
// both branch conditions and PC wrap-around.
module tb_cpu8_ctrl_exec;

    logic        clk_i;
    logic        rst_ni;
    logic [12:0] instr_i;
    logic [7:0]  pc_o;
    logic [2:0]  rd_addr_a_o;
    logic [2:0]  rd_addr_b_o;
    logic [2:0]  dec_opcode_o;
    logic        dec_wr_en_o;
    logic [2:0]  dec_wr_addr_o;
    logic [7:0]  operand_a_i;
    logic [7:0]  operand_b_i;
    logic [2:0]  exe_opcode_i;
    logic [7:0]  result_o;
    logic        flg_gr_o;
    logic        flg_eq_o;
    logic        branch_taken_o;

    int err_cnt = 0;
    int chk_cnt = 0;

    cpu8_ctrl_exec #(
        .PC_W   (8),
        .DATA_W (8)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .instr_i        (instr_i),
        .pc_o           (pc_o),
        .rd_addr_a_o    (rd_addr_a_o),
        .rd_addr_b_o    (rd_addr_b_o),
        .dec_opcode_o   (dec_opcode_o),
        .dec_wr_en_o    (dec_wr_en_o),
        .dec_wr_addr_o  (dec_wr_addr_o),
        .operand_a_i    (operand_a_i),
        .operand_b_i    (operand_b_i),
        .exe_opcode_i   (exe_opcode_i),
        .result_o       (result_o),
        .flg_gr_o       (flg_gr_o),
        .flg_eq_o       (flg_eq_o),
        .branch_taken_o (branch_taken_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %-14s got=%h expected=%h", tag, got, exp);
        end else begin
            $display("  ok %-14s = %h", tag, got);
        end
    endtask

    // Inputs change just after the falling edge; outputs are sampled there too.
    task automatic next_cycle();
        @(negedge clk_i);
    endtask

    localparam logic [7:0] SWEEP_EXP [8] = '{8'h0F, 8'hD1, 8'h10, 8'hFF,
                                             8'hEF, 8'h0F, 8'hE0, 8'h78};

    initial begin
        // Reset held over two edges while a branch would otherwise be taken
        rst_ni       = 1'b0;
        instr_i      = {1'b1, 3'b000, 1'b0, 8'h40};
        operand_a_i  = 8'd5;
        operand_b_i  = 8'd5;
        exe_opcode_i = 3'b000;
        next_cycle();
        next_cycle();
        check("rst_branch", 16'(branch_taken_o), 16'd1);
        check("rst_pc", 16'(pc_o), 16'h00);

        rst_ni  = 1'b1;
        instr_i = 13'b0_000_000_000_000;
        for (int i = 1; i <= 3; i++) begin
            next_cycle();
            check($sformatf("count_pc%0d", i), 16'(pc_o), 16'(i));
        end

        // Decode of an ALU instruction
        instr_i = 13'b0_011_000_000_001;
        #1;
        check("dec_op", 16'(dec_opcode_o), 16'h3);
        check("dec_ra", 16'(rd_addr_a_o), 16'h0);
        check("dec_rb", 16'(rd_addr_b_o), 16'h0);
        check("dec_rd", 16'(dec_wr_addr_o), 16'h1);
        check("dec_we", 16'(dec_wr_en_o), 16'h1);
        check("dec_br", 16'(branch_taken_o), 16'h0);

        instr_i = 13'b0_001_101_110_011;
        #1;
        check("dec2_op", 16'(dec_opcode_o), 16'h1);
        check("dec2_ra", 16'(rd_addr_a_o), 16'h5);
        check("dec2_rb", 16'(rd_addr_b_o), 16'h6);
        check("dec2_rd", 16'(dec_wr_addr_o), 16'h3);

        // Branch decode: addresses forced to zero, no write
        operand_a_i = 8'd1;
        operand_b_i = 8'd2;
        instr_i     = {1'b1, 3'b101, 1'b1, 8'hFF};
        #1;
        check("decb_op", 16'(dec_opcode_o), 16'h5);
        check("decb_we", 16'(dec_wr_en_o), 16'h0);
        check("decb_ra", 16'(rd_addr_a_o), 16'h0);
        check("decb_rb", 16'(rd_addr_b_o), 16'h0);
        check("decb_rd", 16'(dec_wr_addr_o), 16'h0);
        check("decb_taken", 16'(branch_taken_o), 16'h0);
        instr_i = 13'b0_000_000_000_000;

        // ALU sweep at a=F0, b=1F
        operand_a_i = 8'hF0;
        operand_b_i = 8'h1F;
        for (int op = 0; op < 8; op++) begin
            exe_opcode_i = 3'(op);
            #1;
            check($sformatf("alu_op%0d", op), 16'(result_o), 16'(SWEEP_EXP[op]));
        end
        check("sweep_gr", 16'(flg_gr_o), 16'h1);
        check("sweep_eq", 16'(flg_eq_o), 16'h0);

        // Edge operands: wrap on ADD/SUB, bits shifted out on SHL/SHR
        operand_a_i = 8'hFF; operand_b_i = 8'h01; exe_opcode_i = 3'b000; #1;
        check("add_wrap", 16'(result_o), 16'h00);
        operand_a_i = 8'h05; operand_b_i = 8'h06; exe_opcode_i = 3'b001; #1;
        check("sub_borrow", 16'(result_o), 16'hFF);
        check("lt_gr", 16'(flg_gr_o), 16'h0);
        operand_a_i = 8'h81; exe_opcode_i = 3'b110; #1;
        check("shl_81", 16'(result_o), 16'h02);
        exe_opcode_i = 3'b111; #1;
        check("shr_81", 16'(result_o), 16'h40);
        operand_b_i = 8'h81; #1;
        check("eq_flag", 16'(flg_eq_o), 16'h1);
        check("eq_gr", 16'(flg_gr_o), 16'h0);

        // Branch-equal: taken with a==b, not taken otherwise
        next_cycle();
        instr_i     = {1'b1, 3'b000, 1'b0, 8'h40};
        operand_a_i = 8'd5;
        operand_b_i = 8'd5;
        #1;
        check("beq_taken", 16'(branch_taken_o), 16'h1);
        next_cycle();
        check("beq_pc", 16'(pc_o), 16'h40);
        operand_a_i = 8'd6;
        #1;
        check("beq_not", 16'(branch_taken_o), 16'h0);
        next_cycle();
        check("beq_not_pc", 16'(pc_o), 16'h41);

        // Branch-greater
        instr_i     = {1'b1, 3'b001, 1'b0, 8'h10};
        operand_a_i = 8'd6;
        operand_b_i = 8'd5;
        #1;
        check("bgr_taken", 16'(branch_taken_o), 16'h1);
        next_cycle();
        check("bgr_pc", 16'(pc_o), 16'h10);
        operand_a_i = 8'd5;
        operand_b_i = 8'd6;
        #1;
        check("bgr_not", 16'(branch_taken_o), 16'h0);
        next_cycle();
        check("bgr_not_pc", 16'(pc_o), 16'h11);
        operand_b_i = 8'd5;
        #1;
        check("bgr_eq_not", 16'(branch_taken_o), 16'h0);

        // Opcode bits [2:1] are ignored: 111 behaves as branch-greater
        instr_i     = {1'b1, 3'b111, 1'b0, 8'h20};
        operand_a_i = 8'd9;
        operand_b_i = 8'd3;
        #1;
        check("b111_taken", 16'(branch_taken_o), 16'h1);
        next_cycle();
        check("b111_pc", 16'(pc_o), 16'h20);

        // Wrap: branch to 0xFE then free-run
        instr_i     = {1'b1, 3'b000, 1'b0, 8'hFE};
        operand_a_i = 8'd7;
        operand_b_i = 8'd7;
        next_cycle();
        check("wrap_pc254", 16'(pc_o), 16'hFE);
        instr_i = 13'b0_000_001_010_011;
        next_cycle();
        check("wrap_pc255", 16'(pc_o), 16'hFF);
        next_cycle();
        check("wrap_pc0", 16'(pc_o), 16'h00);

        // Reset dominates a taken branch mid-run
        instr_i = {1'b1, 3'b000, 1'b0, 8'h77};
        rst_ni  = 1'b0;
        next_cycle();
        check("rst_mid_pc", 16'(pc_o), 16'h00);
        rst_ni = 1'b1;

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
